vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Drives the VGA raster for 640x480 at 60 Hz.
- Free-running horizontal/vertical counters produce column/row coordinates, the active-video flag and sync pulses.
- The pixel pattern generator consumes the coordinates and returns a 3-bit colour. This block registers that colour, blanks it outside the visible area and aligns it with hsync/vsync for the DAC/pins.
- It is the consumer/driver end of the row/column -> rgb pixel interface.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels); line total = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines); frame total = 525

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  synchronous reset, active-low
- pix_en_i  input  1  pixel strobe; all state advances only on clk_i edges with pix_en_i=1 (1/2 rate from 50 MHz gives 25 MHz pixels)
- rgb_i  input  3  colour from pattern generator for current column_o/row_o
- column_o  output  10  current pixel column, 0..639; 0 in blanking
- row_o  output  9  current pixel row, 0..479; 0 in blanking
- active_o  output  1  1 when current counters are inside the visible area
- frame_o  output  1  one-clk pulse marking start of a new frame
- hsync_o  output  1  horizontal sync, active-low
- vsync_o  output  1  vertical sync, active-low
- rgb_o  output  3  blanked, sync-aligned colour to DAC/pins

Behaviour:
- One clock. Reset is synchronous, active-low: rst_ni sampled on clk_i rising edge; rst_ni=0 overrides pix_en_i.
- Reset values:
  - h_cnt=0, v_cnt=0 (so column_o=0, row_o=0, active_o=1)
  - rgb_o=3'b000, hsync_o=1, vsync_o=1, frame_o=0
- Counters (stage 0), on pix_en_i=1:
  - h_cnt increments and wraps 799->0.
  - v_cnt increments only when h_cnt wraps; v_cnt wraps 524->0.
  - pix_en_i=0 holds every register, including the pipeline; frame_o is the exception and is forced 0.
- Derived from the counter registers, with no extra latency:
  - active_o = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)
  - column_o = active_o ? h_cnt : 0
  - row_o = active_o ? v_cnt[8:0] : 0
- Output stage (stage 1), registered on pix_en_i=1; one pixel of latency from coordinates to rgb_o/hsync_o/vsync_o:
  - rgb_o <= active_o ? rgb_i : 3'b000
  - hsync_o <= ~(h_cnt in [656,751])
  - vsync_o <= ~(v_cnt in [490,491])
  - Boundaries are computed from the parameters: start = ACTIVE+FP, end = ACTIVE+FP+SYNC-1.
- rgb_i is sampled in the same cycle as the coordinates it answers. The pattern generator must be combinational with respect to column_o/row_o.
- frame_o:
  - Set to 1 for exactly one clk_i cycle following the edge on which the counters go (799,524)->(0,0).
  - Forced 0 in every other cycle.
  - Reset itself does not produce a pulse.
- Reset mid-frame: the counters restart at (0,0) on the next edge and the outputs return to their reset values. No partial sync pulse remains asserted.
- Widths: h_cnt is 10 bits and v_cnt is 10 bits internally; row_o is truncated to 9 bits, which is valid because row_o is 0 outside the active area.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: in stage 1, any active pixel with column 0, column 639, row 0 or row 479 drives rgb_o=3'b111 regardless of rgb_i. Latency and blanking are unchanged.
- Undefined: rgb_o is exactly the blanked rgb_i; no border logic is synthesised.

Test Plan:
- Reset, pix_en_i=1 continuous, rgb_i=3'b100 -> first rgb_o=3'b100 appears one pixel after reset release; hsync_o low for exactly 96 consecutive pixels starting at output pixel 657 of each line; line period = 800 strobes.
- Run 2 full frames -> vsync_o low for exactly 2 lines (1600 strobes) per frame; frame_o pulses once every 420000 strobes, never during reset.
- rgb_i held 3'b111 -> rgb_o=3'b000 for every output pixel with h_cnt>=640 or v_cnt>=480; column_o/row_o read 0 there; max column_o=639, max row_o=479.
- pix_en_i toggled 1,0,1,0 -> counters and outputs change only on strobe cycles; behaviour is identical to the continuous run with time doubled.
- Assert rst_ni=0 at (h=300,v=200) while pix_en_i=0 -> reset still takes effect on that edge; after release the counters restart at (0,0), hsync_o=vsync_o=1 and frame_o stays 0.
- VGA_BORDER_EN defined, rgb_i=3'b010 -> rgb_o=3'b111 at (0,0), (639,5), (5,479); 3'b010 at (1,1).

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Purpose: pixel coordinate / colour link between the raster timing generator and a pattern generator.
// Latency: none; plain wires, the pattern generator answers combinationally within the same cycle.
// Backpressure: none; the raster is free-running and the colour must be valid every cycle.
//
// Signals:
//   column_o  [9:0]  current visible column (0 in blanking), driven by the timing generator
//   row_o     [8:0]  current visible row (0 in blanking), driven by the timing generator
//   active_o         high while the counters sit inside the visible area
//   rgb_i     [2:0]  colour for (column_o, row_o), driven by the pattern generator
// Modports: master = timing generator end, slave = pattern generator end.
interface vga_timing_gen_if;
  logic [9:0] column_o;
  logic [8:0] row_o;
  logic       active_o;
  logic [2:0] rgb_i;

  modport master (
    output column_o,
    output row_o,
    output active_o,
    input  rgb_i
  );

  modport slave (
    input  column_o,
    input  row_o,
    input  active_o,
    output rgb_i
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Purpose: 640x480@60 VGA raster counters, sync pulses and blanked, sync-aligned colour output.
// Latency: coordinates/active are combinational from the counters; rgb/hsync/vsync lag them by one pixel strobe.
// Backpressure: none; pix_en_i=0 freezes every register (frame_o forced low), nothing is ever dropped.
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset, overrides pix_en_i
//   pix_en_i       pixel strobe, all state advances only when high
//   pix            vga_timing_gen_if.master: column_o/row_o/active_o out, rgb_i in
//   frame_o        one-cycle pulse after the counters wrap (799,524)->(0,0)
//   hsync_o        horizontal sync, active-low
//   vsync_o        vertical sync, active-low
//   rgb_o          blanked colour aligned with hsync_o/vsync_o
// Build option: define VGA_BORDER_EN to force a white 1-pixel border around the visible area.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pix_en_i,
  vga_timing_gen_if.master        pix,
  output logic                    frame_o,
  output logic                    hsync_o,
  output logic                    vsync_o,
  output logic [2:0]              rgb_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All raster constants pre-sized to the 10-bit counters.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Stage 0: raster position.
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  logic       h_wrap;
  logic       v_wrap;
  logic       in_active;
  logic       h_sync_zone;
  logic       v_sync_zone;
  logic [2:0] rgb_next;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  assign in_active = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  assign h_sync_zone = (h_cnt >= HS_START) && (h_cnt <= HS_END);
  assign v_sync_zone = (v_cnt >= VS_START) && (v_cnt <= VS_END);

  // Coordinates are zeroed in blanking, which is what makes dropping v_cnt[9] on row_o safe.
  assign pix.active_o = in_active;
  assign pix.column_o = in_active ? h_cnt : 10'd0;
  assign pix.row_o    = in_active ? v_cnt[8:0] : 9'd0;

`ifdef VGA_BORDER_EN
  localparam logic [9:0] H_VIS_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);

  logic on_border;

  assign on_border = in_active &&
                     ((h_cnt == 10'd0) || (h_cnt == H_VIS_LAST) ||
                      (v_cnt == 10'd0) || (v_cnt == V_VIS_LAST));

  always_comb begin
    rgb_next = in_active ? pix.rgb_i : 3'b000;
    if (on_border) begin
      rgb_next = 3'b111;
    end
  end
`else
  always_comb begin
    rgb_next = in_active ? pix.rgb_i : 3'b000;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
      frame_o <= 1'b0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      rgb_o   <= 3'b000;
    end else begin
      // frame_o is a strobe, not state: it drops on the next clock even when the pixel strobe is idle.
      frame_o <= 1'b0;
      if (pix_en_i) begin
        h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
        if (h_wrap) begin
          v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
        end
        frame_o <= h_wrap && v_wrap;
        // Stage 1: colour and syncs for the pixel the counters point at now.
        rgb_o   <= rgb_next;
        hsync_o <= ~h_sync_zone;
        vsync_o <= ~v_sync_zone;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: self-checking bench for vga_timing_gen; a full-size and a shrunk-raster instance share stimulus.
// Latency: model predicts the one-strobe output stage from the strobe count since reset.
// Backpressure: pix_en is driven continuous, toggled and random to exercise stalls.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic pix_en;
  logic use_pat;
  logic [2:0] kcol;

  int n_cmp = 0;
  int n_bad = 0;

  // Raster geometry per instance: 0 = 640x480, 1 = shrunk 16x6 raster.
  function automatic int p_ha(input int d); return (d == 0) ? 640 : 16; endfunction
  function automatic int p_hf(input int d); return (d == 0) ? 16  : 2;  endfunction
  function automatic int p_hs(input int d); return (d == 0) ? 96  : 4;  endfunction
  function automatic int p_hb(input int d); return (d == 0) ? 48  : 3;  endfunction
  function automatic int p_va(input int d); return (d == 0) ? 480 : 6;  endfunction
  function automatic int p_vf(input int d); return (d == 0) ? 10  : 2;  endfunction
  function automatic int p_vs(input int d); return (d == 0) ? 2   : 2;  endfunction
  function automatic int p_vb(input int d); return (d == 0) ? 33  : 3;  endfunction
  function automatic int ht(input int d); return p_ha(d) + p_hf(d) + p_hs(d) + p_hb(d); endfunction
  function automatic int vt(input int d); return p_va(d) + p_vf(d) + p_vs(d) + p_vb(d); endfunction

  // Pattern generator: constant colour, or a checker derived from the coordinates.
  function automatic logic [2:0] pat(input logic up, input logic [2:0] k,
                                     input logic [9:0] c, input logic [8:0] r);
    return up ? (c[2:0] ^ r[2:0] ^ k) : k;
  endfunction

  vga_timing_gen_if pix0 ();
  vga_timing_gen_if pix1 ();

  logic       fr_w  [2];
  logic       hs_w  [2];
  logic       vs_w  [2];
  logic [2:0] rgb_w [2];
  logic [9:0] col_w [2];
  logic [8:0] row_w [2];
  logic       act_w [2];

  assign pix0.rgb_i = pat(use_pat, kcol, pix0.column_o, pix0.row_o);
  assign pix1.rgb_i = pat(use_pat, kcol, pix1.column_o, pix1.row_o);
  assign col_w[0] = pix0.column_o;
  assign col_w[1] = pix1.column_o;
  assign row_w[0] = pix0.row_o;
  assign row_w[1] = pix1.row_o;
  assign act_w[0] = pix0.active_o;
  assign act_w[1] = pix1.active_o;

  vga_timing_gen dut0 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .pix_en_i (pix_en),
    .pix      (pix0),
    .frame_o  (fr_w[0]),
    .hsync_o  (hs_w[0]),
    .vsync_o  (vs_w[0]),
    .rgb_o    (rgb_w[0])
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) dut1 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .pix_en_i (pix_en),
    .pix      (pix1),
    .frame_o  (fr_w[1]),
    .hsync_o  (hs_w[1]),
    .vsync_o  (vs_w[1]),
    .rgb_o    (rgb_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the raster position is simply the strobe count since reset, folded by line and frame length.
  bit         mv = 1'b0;
  int         m_n   [2];
  logic [2:0] e_rgb [2];
  logic       e_hs  [2];
  logic       e_vs  [2];
  logic       e_fr  [2];

  always @(posedge clk) begin : model
    int h, v;
    logic act;
    if (!rst_n) begin
      mv = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_n[d] = 0; e_rgb[d] = 3'b000; e_hs[d] = 1'b1; e_vs[d] = 1'b1; e_fr[d] = 1'b0;
      end
    end else if (mv) begin
      for (int d = 0; d < 2; d++) begin
        e_fr[d] = 1'b0;
        if (pix_en) begin
          h   = m_n[d] % ht(d);
          v   = (m_n[d] / ht(d)) % vt(d);
          act = (h < p_ha(d)) && (v < p_va(d));
          e_rgb[d] = act ? pat(use_pat, kcol, 10'(h), 9'(v)) : 3'b000;
`ifdef VGA_BORDER_EN
          if (act && (h == 0 || h == p_ha(d) - 1 || v == 0 || v == p_va(d) - 1)) e_rgb[d] = 3'b111;
`endif
          e_hs[d] = !(h >= p_ha(d) + p_hf(d) && h < p_ha(d) + p_hf(d) + p_hs(d));
          e_vs[d] = !(v >= p_va(d) + p_vf(d) && v < p_va(d) + p_vf(d) + p_vs(d));
          m_n[d]++;
          if (m_n[d] % (ht(d) * vt(d)) == 0) e_fr[d] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    int h, v;
    logic act;
    if (mv) begin
      for (int d = 0; d < 2; d++) begin
        h   = m_n[d] % ht(d);
        v   = (m_n[d] / ht(d)) % vt(d);
        act = (h < p_ha(d)) && (v < p_va(d));
        chk($sformatf("dut%0d.active", d), 32'(act_w[d]), 32'(act));
        chk($sformatf("dut%0d.column", d), 32'(col_w[d]), act ? h : 0);
        chk($sformatf("dut%0d.row", d),    32'(row_w[d]), act ? v : 0);
        chk($sformatf("dut%0d.frame", d),  32'(fr_w[d]),  32'(e_fr[d]));
        chk($sformatf("dut%0d.hsync", d),  32'(hs_w[d]),  32'(e_hs[d]));
        chk($sformatf("dut%0d.vsync", d),  32'(vs_w[d]),  32'(e_vs[d]));
        chk($sformatf("dut%0d.rgb", d),    32'(rgb_w[d]), 32'(e_rgb[d]));
      end
    end
  end

  // Directed observations that pin the model to hand-computed numbers.
  int         phase = 0;
  int         hs_first = -1, hs_second = -1, hs_low = 0, vs_low = 0;
  int         fr_cnt = 0, fr_first = -1;
  int         max_c0 = 0, max_c1 = 0, max_r1 = 0;
  logic [2:0] rgb_at1 = 3'bxxx;

  always @(negedge clk) begin : monitor
    if (mv) begin
      if (int'(col_w[0]) > max_c0) max_c0 = int'(col_w[0]);
      if (int'(col_w[1]) > max_c1) max_c1 = int'(col_w[1]);
      if (int'(row_w[1]) > max_r1) max_r1 = int'(row_w[1]);
      if (phase == 1) begin
        if (hs_w[0] === 1'b0) begin
          if (m_n[0] <= 800) hs_low++;
          if (hs_first < 0) hs_first = m_n[0];
          else if (m_n[0] > 800 && hs_second < 0) hs_second = m_n[0];
        end
        if (vs_w[1] === 1'b0 && m_n[1] >= 1 && m_n[1] <= 325) vs_low++;
        if (fr_w[1] === 1'b1) begin
          fr_cnt++;
          if (fr_first < 0) fr_first = m_n[1];
        end
        if (m_n[0] == 1) rgb_at1 = rgb_w[0];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    bit hit;
    rst_n   = 1'b0;
    pix_en  = 1'b1;
    use_pat = 1'b0;
    kcol    = 3'b100;

    // Reset with the strobe active: reset must win.
    step();
    phase = 1;
    step();
    step();
    rst_n = 1'b1;

    // Continuous strobes, constant colour 3'b100.
    repeat (2001) step();
    @(negedge clk);
    phase = 2;
    chk("first_rgb", 32'(rgb_at1), 32'd4);
    chk("hsync_first_low", hs_first, 657);
    chk("hsync_low_width", hs_low, 96);
    chk("hsync_line_period", hs_second, 1457);
    chk("vsync_low_width_small", vs_low, 50);
    chk("frame_first_small", fr_first, 325);
    chk("frame_count_small", fr_cnt, 6);

    // White input: blanking must still force black.
    kcol = 3'b111;
    repeat (1000) step();

    // Half-rate strobe with a coordinate-dependent pattern.
    use_pat = 1'b1;
    kcol    = 3'b001;
    for (int i = 0; i < 1800; i++) begin
      step();
      pix_en = ~pix_en;
    end

    // Reset the small raster at (8,3) while the strobe is low.
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step();
      if (m_n[1] % 325 == 83) hit = 1'b1;
      else pix_en = ~pix_en;
    end
    chk("wait_small_midframe", 32'(hit), 32'd1);
    pix_en = 1'b0;
    rst_n  = 1'b0;
    step();
    rst_n  = 1'b1;
    @(negedge clk);
    chk("midreset_col", 32'(col_w[1]), 32'd0);
    chk("midreset_hsync", 32'(hs_w[1]), 32'd1);
    chk("midreset_frame", 32'(fr_w[1]), 32'd0);

    // Reset the full raster in the middle of an hsync pulse.
    pix_en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      step();
      if (m_n[0] % 800 == 700) hit = 1'b1;
    end
    chk("wait_in_hsync", 32'(hit), 32'd1);
    chk("hsync_low_before_reset", 32'(hs_w[0]), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_clears_hsync", 32'(hs_w[0]), 32'd1);

    // Random strobe pattern.
    for (int i = 0; i < 1500; i++) begin
      step();
      pix_en = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("max_column_full", max_c0, 639);
    chk("max_column_small", max_c1, 15);
    chk("max_row_small", max_r1, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
